// File: rtl/spi_burst_feeder.sv
// Byte FIFO that feeds an SPI master in CS_n-framed bursts of back-to-back bytes.
// Latency: CS_n falls two cycles after a write into an empty idle FIFO; first o_TX_DV follows CS_LEAD_CLKS cycles later.
// Backpressure: writes into a full FIFO are dropped with an o_Overflow pulse; bytes are offered only once i_TX_Ready=1.
module spi_burst_feeder #(
  parameter int DEPTH        = 8,
  parameter int CS_LEAD_CLKS = 2,
  parameter int CS_GAP_CLKS  = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Full,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Ready,
  output logic                   o_SPI_CS_n,
  output logic                   o_Busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (CS_LEAD_CLKS > CS_GAP_CLKS) ? CS_LEAD_CLKS : CS_GAP_CLKS;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SEND,
    S_HOLD,
    S_WAIT,
    S_GAP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          wr_acc;
  logic          pop;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          cs_n_q;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;

  assign o_Full     = (count_q == (AW+1)'(DEPTH));
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_SPI_CS_n = cs_n_q;
  assign o_Busy     = (state_q != S_IDLE);

  // A write is taken only when not full; the head leaves only at the end of a SEND cycle
  assign wr_acc = i_Wr_DV && !o_Full;
  assign pop    = (state_q == S_SEND) && (count_q != '0);

  // FIFO next-state: pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = i_Wr_DV && o_Full;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the one-cycle overflow pulse
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; writes are ignored while reset is asserted
  always_ff @(posedge i_Clk) begin
    if (i_Rst_L && wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  // Burst sequencer: CS_n, TX_DV and TX_Byte are all registered here
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Start decision uses the pre-write count
          if ((count_q != '0) && i_TX_Ready) begin
            state_q <= S_LEAD;
            cs_n_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_LEAD: begin
          if (cnt_q == CW'(CS_LEAD_CLKS - 1)) begin
            state_q   <= S_SEND;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= mem_q[rd_ptr_q];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SEND: state_q <= S_HOLD;
        // The master lowers ready on the edge that took DV, so it is not looked at here
        S_HOLD: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_TX_Ready) begin
            if (count_q != '0) begin
              state_q   <= S_SEND;
              tx_dv_q   <= 1'b1;
              tx_byte_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= S_GAP;
              cs_n_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(CS_GAP_CLKS - 1)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_feeder.sv
// Randomized and directed bench for spi_burst_feeder with a queue-based reference model.
// Stimulus pushes accepted bytes into a scoreboard queue; a negedge monitor checks TX bytes and framing.
// A master model lowers ready for a programmable number of cycles after each TX_DV pulse.
module tb_spi_burst_feeder;

  localparam int DEPTH = 8;
  localparam int LEAD  = 2;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       i_Rst_L;
  logic       i_Wr_DV;
  logic [7:0] i_Wr_Byte;
  logic       o_Full;
  logic [3:0] o_Count;
  logic       o_Overflow;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Ready;
  logic       o_SPI_CS_n;
  logic       o_Busy;

  always #5 clk = ~clk;

  spi_burst_feeder #(.DEPTH(DEPTH), .CS_LEAD_CLKS(LEAD), .CS_GAP_CLKS(GAP)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (i_Rst_L),
    .i_Wr_DV    (i_Wr_DV),
    .i_Wr_Byte  (i_Wr_Byte),
    .o_Full     (o_Full),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .o_TX_DV    (o_TX_DV),
    .o_TX_Byte  (o_TX_Byte),
    .i_TX_Ready (i_TX_Ready),
    .o_SPI_CS_n (o_SPI_CS_n),
    .o_Busy     (o_Busy)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         pend_acc = 0;
  bit         ovf_pend = 0;
  bit         force_low = 0;
  bit         mon_en = 0;
  int         hold = 0;
  int         hold_len = 16;
  int         dv_total = 0;
  int         dv_last = 0;
  int         cyc = 0;
  int         ovf_total = 0;
  int         bursts = 0;
  int         last_len = 0;
  int         cur_len = 0;
  int         cs_fall_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs change 2 time units after the rising edge
  task automatic step(input bit do_wr, input logic [7:0] b, input bit rst);
    @(posedge clk);
    #2;
    if (dv_total != dv_last) begin
      dv_last = dv_total;
      hold    = hold_len;
    end else if (hold > 0) begin
      hold--;
    end
    i_TX_Ready = !force_low && (hold == 0);
    i_Rst_L    = !rst;
    i_Wr_DV    = do_wr;
    i_Wr_Byte  = b;
    pend_acc   = 0;
    ovf_pend   = 0;
    if (do_wr && !rst) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(b);
        pend_acc = 1;
      end else begin
        ovf_pend = 1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_Busy) && n < 3000) begin
      step(0, 8'h00, 0);
      n++;
    end
    chk({name, "_drain_in_time"}, int'(n < 3000), 1);
  endtask

  // Monitor: occupancy, overflow, framing and scoreboard pops, sampled on the falling edge
  initial begin : monitor
    bit         cs_prev;
    bit         ovf_prev;
    bit         rst_prev;
    bit         gap_valid;
    int         high_len;
    int         mcnt;
    logic [7:0] last_byte;
    logic [7:0] e;
    cs_prev = 1; ovf_prev = 0; rst_prev = 0; gap_valid = 0; high_len = 0; last_byte = 8'h00;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cyc++;
      mcnt = exp_q.size() - int'(pend_acc);
      chk("count", int'(o_Count), mcnt);
      chk("full", int'(o_Full), int'(mcnt == DEPTH));
      chk("overflow", int'(o_Overflow), int'(ovf_prev));
      if (o_Overflow) ovf_total++;
      if (!o_SPI_CS_n) chk("busy_in_burst", int'(o_Busy), 1);
      if (!o_SPI_CS_n && cs_prev) begin
        if (gap_valid) chk("cs_high_run", int'(high_len >= GAP + 1), 1);
        cs_fall_cyc = cyc;
        cur_len = 0;
      end
      if (o_SPI_CS_n && !cs_prev) begin
        bursts++;
        last_len  = cur_len;
        gap_valid = rst_prev;
        high_len  = 0;
      end
      if (o_SPI_CS_n) high_len++;
      if (o_TX_DV) begin
        dv_total++;
        chk("dv_cs_low", int'(o_SPI_CS_n), 0);
        chk("dv_ready_high", int'(i_TX_Ready), 1);
        if (cur_len == 0) chk("lead_len", cyc - cs_fall_cyc, LEAD);
        cur_len++;
        chk("dv_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", int'(o_TX_Byte), int'(e));
        end
        last_byte = o_TX_Byte;
      end else begin
        chk("tx_byte_hold", int'(o_TX_Byte), int'(last_byte));
      end
      ovf_prev = ovf_pend;
      cs_prev  = o_SPI_CS_n;
      if (!i_Rst_L) begin
        exp_q.delete();
        last_byte = 8'h00;
        gap_valid = 0;
        ovf_prev  = 0;
      end
      rst_prev = i_Rst_L;
    end
  end

  initial begin : driver
    int b0, d0, o0, wcyc, n;
    i_Rst_L = 1'b0; i_Wr_DV = 1'b0; i_Wr_Byte = 8'h00; i_TX_Ready = 1'b1;

    // Reset state
    step(0, 8'h00, 1);
    mon_en = 1;
    step(0, 8'h00, 1);
    chk("rst_count", int'(o_Count), 0);
    chk("rst_full", int'(o_Full), 0);
    chk("rst_overflow", int'(o_Overflow), 0);
    chk("rst_tx_dv", int'(o_TX_DV), 0);
    chk("rst_tx_byte", int'(o_TX_Byte), 0);
    chk("rst_cs_n", int'(o_SPI_CS_n), 1);
    chk("rst_busy", int'(o_Busy), 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    // Single byte into an idle, empty FIFO
    hold_len = 16;
    b0 = bursts; d0 = dv_total;
    step(1, 8'h61, 0);
    wcyc = cyc;
    drain("single");
    chk("single_cs_fall_cycle", cs_fall_cyc - wcyc, 3);
    chk("single_bursts", bursts - b0, 1);
    chk("single_len", last_len, 1);
    chk("single_dv_count", dv_total - d0, 1);
    chk("single_busy_idle", int'(o_Busy), 0);
    chk("single_cs_high", int'(o_SPI_CS_n), 1);

    // Three-byte burst on consecutive cycles
    b0 = bursts; d0 = dv_total;
    step(1, 8'h61, 0);
    step(1, 8'h62, 0);
    chk("burst_count_1", int'(o_Count), 1);
    step(1, 8'h63, 0);
    chk("burst_count_2", int'(o_Count), 2);
    step(0, 8'h00, 0);
    chk("burst_count_3", int'(o_Count), 3);
    drain("burst");
    chk("burst_windows", bursts - b0, 1);
    chk("burst_len", last_len, 3);
    chk("burst_dv_count", dv_total - d0, 3);
    chk("burst_count_end", int'(o_Count), 0);

    // Fill with ready held low, then overflow
    force_low = 1;
    step(0, 8'h00, 0);
    o0 = ovf_total; d0 = dv_total; b0 = bursts;
    for (int i = 0; i < 9; i++) begin
      step(1, 8'(i), 0);
    end
    chk("full_after_8th", int'(o_Full), 1);
    step(0, 8'h00, 0);
    chk("ovf_pulse", int'(o_Overflow), 1);
    chk("ovf_count_stays", int'(o_Count), 8);
    step(0, 8'h00, 0);
    chk("ovf_once", ovf_total - o0, 1);
    chk("ovf_pulse_gone", int'(o_Overflow), 0);
    force_low = 0;
    drain("full");
    chk("full_dv_count", dv_total - d0, 8);
    chk("full_windows", bursts - b0, 1);

    // Pointer wrap: three drained rounds of six bytes
    d0 = dv_total;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        step(1, 8'h10 + 8'(r * 6 + i), 0);
      end
      drain("wrap");
    end
    chk("wrap_dv_count", dv_total - d0, 18);

    // Mid-burst extension: second byte written while waiting on ready
    b0 = bursts; d0 = dv_total;
    step(1, 8'hA0, 0);
    n = 0;
    while (dv_total == d0 && n < 100) begin
      step(0, 8'h00, 0);
      n++;
    end
    chk("ext_first_dv_in_time", int'(n < 100), 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("ext_cs_still_low", int'(o_SPI_CS_n), 0);
    step(1, 8'hA1, 0);
    drain("ext");
    chk("ext_windows", bursts - b0, 1);
    chk("ext_len", last_len, 2);

    // Reset in the middle of a four-byte burst
    d0 = dv_total;
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0);
    n = 0;
    while (dv_total < d0 + 2 && n < 200) begin
      step(0, 8'h00, 0);
      n++;
    end
    chk("rst_mid_two_dv_in_time", int'(n < 200), 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("rst_mid_cs_n", int'(o_SPI_CS_n), 1);
    chk("rst_mid_count", int'(o_Count), 0);
    chk("rst_mid_busy", int'(o_Busy), 0);
    chk("rst_mid_tx_dv", int'(o_TX_DV), 0);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 0);
    chk("rst_mid_no_more_dv", dv_total - d0, 2);
    step(1, 8'hD5, 0);
    drain("rst_recover");
    chk("rst_recover_dv", dv_total - d0, 3);

    // Randomized traffic with variable master stalls and occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) < 5) begin
        if (force_low) force_low = 0;
        else if (!o_Busy) force_low = 1;
      end
      hold_len = $urandom_range(1, 20);
      step(($urandom_range(0, 99) < 35), 8'($urandom), ($urandom_range(0, 399) == 0));
    end
    force_low = 0;
    step(0, 8'h00, 0);
    drain("random");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_burst_feeder.md
SPI_BURST_FEEDER -- requirements
Module: spi_burst_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8; FIFO depth in bytes; power of two, 2..64.
REQ-002 SHALL have parameter CS_LEAD_CLKS, default 2; CS_n-low cycles before the first byte of a burst; at least 1.
REQ-003 SHALL have parameter CS_GAP_CLKS, default 4; minimum CS_n-high cycles between bursts; at least 1.
REQ-004 SHALL have one clock and a synchronous, active-low reset, with the following ports:
- i_Clk  in  1  single clock; all logic on the rising edge.
- i_Rst_L  in  1  synchronous, active-low reset.
- i_Wr_DV  in  1  one-cycle write strobe for i_Wr_Byte.
- i_Wr_Byte  in  8  byte to enqueue.
- o_Full  out  1  FIFO holds DEPTH bytes.
- o_Count  out  log2(DEPTH)+1  bytes currently queued.
- o_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_TX_DV  out  1  one-cycle pulse to the SPI master TX data-valid input.
- o_TX_Byte  out  8  byte presented to the SPI master; valid while o_TX_DV=1.
- i_TX_Ready  in  1  SPI master ready; the master drives it low on the edge that samples o_TX_DV.
- o_SPI_CS_n  out  1  active-low chip select framing a burst.
- o_Busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement a circular FIFO of DEPTH x 8 with read/write pointers that wrap modulo DEPTH.
REQ-006 SHALL accept a write when i_Wr_DV=1 and o_Full=0, as sampled at that cycle's edge; o_Count increments on the next cycle.
REQ-007 SHALL drop the byte when i_Wr_DV=1 and o_Full=1, and pulse o_Overflow for exactly 1 cycle; this applies even if a pop occurs the same cycle.
REQ-008 SHALL leave o_Count unchanged on a simultaneous accepted write and pop.
REQ-009 SHALL never underflow; a pop occurs only in SEND with o_Count>0.
REQ-010 SHALL implement the following registered state machine:
- IDLE: CS_n=1. If o_Count>0 and i_TX_Ready=1, go to LEAD and drive CS_n=0 from the next cycle.
- LEAD: CS_n=0 for exactly CS_LEAD_CLKS cycles, then go to SEND.
- SEND: for one cycle drive o_TX_DV=1 and o_TX_Byte=FIFO head, pop the head, then go to HOLD.
- HOLD: exactly 1 cycle, with i_TX_Ready ignored, then go to WAIT.
- WAIT: hold CS_n=0 until i_TX_Ready=1. Then go to SEND if o_Count>0 (so bytes written mid-burst extend the burst), or to GAP if o_Count=0.
- GAP: CS_n=1 for exactly CS_GAP_CLKS cycles, then go to IDLE.
REQ-011 SHALL register o_TX_Byte and hold it stable from the SEND cycle until the next SEND.
REQ-012 SHALL keep o_TX_DV low in every state except SEND, and never pulse it while i_TX_Ready=0.
REQ-013 SHALL hold CS_n low continuously from LEAD entry through the final WAIT, with no glitch between back-to-back bytes.
REQ-014 SHALL, when a write and the IDLE start condition coincide, use the pre-write count; a write into an empty FIFO in IDLE leads to LEAD entry one cycle after o_Count becomes 1.
REQ-015 SHALL derive o_Full = (o_Count == DEPTH) and o_Busy = (state != IDLE), both combinationally from registers.
REQ-016 SHALL size the LEAD and GAP counters to hold max(CS_LEAD_CLKS, CS_GAP_CLKS).

Reset
REQ-017 SHALL, while i_Rst_L=0 at a rising edge, apply the following on the next cycle:
- state=IDLE;
- pointers=0, o_Count=0;
- o_Full=0, o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00;
- o_SPI_CS_n=1, o_Busy=0.
REQ-018 SHALL treat reset mid-burst the same way: queued bytes discarded, CS_n forced high the cycle after reset is sampled, no o_TX_DV in that cycle or after until a new burst starts.
REQ-019 SHALL ignore i_Wr_DV while i_Rst_L=0.

Verification
REQ-020 Single byte: write 8'h61 to an idle, empty FIFO, with the master model holding ready high except 16 cycles after DV.
- CS_n falls, then after 2 cycles o_TX_DV pulses once with o_TX_Byte=8'h61.
- CS_n rises when ready returns; it stays high at least 4 cycles; o_Busy returns to 0.
REQ-021 Burst: write 8'h61,8'h62,8'h63 on consecutive cycles.
- Exactly 3 DV pulses, bytes in order 61,62,63, within one unbroken CS_n-low window.
- o_Count steps 1,2,3 then falls to 0.
REQ-022 Full/overflow: with ready held low, write 9 bytes 8'h00..8'h08.
- o_Full=1 after the 8th write.
- The 9th write pulses o_Overflow once and o_Count stays 8.
- After releasing ready, bytes 00..07 are transmitted and 08 is never sent.
REQ-023 Wrap-around: do 3 rounds of 6 writes, each drained before the next.
- All 18 bytes (8'h10..8'h21) emerge in order, exercising pointer wrap.
REQ-024 Mid-burst extension: write 8'hA0 and, during its WAIT, write 8'hA1.
- Both bytes are sent in the same CS_n-low window, with no GAP between them.
REQ-025 Reset mid-burst: queue 4 bytes and assert i_Rst_L=0 for 1 cycle after the 2nd DV.
- Next cycle: CS_n=1, o_Count=0, o_Busy=0.
- No further DV pulses until a new write.
